// File: rtl/spi_master.sv
// Daisy-chain SPI master, mode 0, one shared ss line.
// Shifts an 8*N_SLAVES-bit frame MSB-first and captures the returning frame.
module spi_master #(
    parameter int N_SLAVES = 2,
    parameter int CLK_DIV  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [8*N_SLAVES-1:0] tx_data,
    output logic [8*N_SLAVES-1:0] rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  ss,
    output logic                  mosi,
    input  logic                  miso
);

    localparam int TOTAL = 8 * N_SLAVES;
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(TOTAL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HI,
        S_LO,
        S_HOLD,
        S_GAP
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [TOTAL-1:0]   r_tx_sh;
    logic [TOTAL-1:0]   r_rx_sh;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               w_div_last;
    logic               w_load;
    logic               w_rise;
    logic               w_fall;
    logic               w_ss_up;
    logic               w_fin;

    assign w_div_last = (r_div_cnt == DIV_W'(CLK_DIV - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and one-cycle action strobes; the last fall skips
    // SHIFT_LO and goes straight to HOLD so ss rises D cycles later.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_rise      = 1'b0;
        w_fall      = 1'b0;
        w_ss_up     = 1'b0;
        w_fin       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_SETUP;
                    w_load      = 1'b1;
                end
            end
            S_SETUP: begin
                if (w_div_last) begin
                    w_state_nxt = S_HI;
                    w_rise      = 1'b1;
                end
            end
            S_HI: begin
                if (w_div_last) begin
                    w_fall = 1'b1;
                    if (r_bit_cnt == BIT_W'(TOTAL - 1)) begin
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_LO;
                    end
                end
            end
            S_LO: begin
                if (w_div_last) begin
                    w_state_nxt = S_HI;
                    w_rise      = 1'b1;
                end
            end
            S_HOLD: begin
                if (w_div_last) begin
                    w_state_nxt = S_GAP;
                    w_ss_up     = 1'b1;
                end
            end
            S_GAP: begin
                if (w_div_last) begin
                    w_state_nxt = S_IDLE;
                    w_fin       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Half-period divider: restarts on every state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div_cnt <= '0;
        end else if (r_state == S_IDLE || w_div_last) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    // Shift registers, bit counter and registered serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_bit_cnt <= '0;
            rx_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sclk      <= 1'b0;
            ss        <= 1'b1;
            mosi      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (w_load) begin
                r_tx_sh   <= tx_data;
                r_rx_sh   <= '0;
                r_bit_cnt <= '0;
                ss        <= 1'b0;
                busy      <= 1'b1;
                mosi      <= tx_data[TOTAL-1];
            end else if (w_rise) begin
                sclk    <= 1'b1;
                r_rx_sh <= {r_rx_sh[TOTAL-2:0], miso};
            end else if (w_fall) begin
                sclk      <= 1'b0;
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_tx_sh   <= {r_tx_sh[TOTAL-2:0], 1'b0};
                mosi      <= r_tx_sh[TOTAL-2];
            end else if (w_ss_up) begin
                ss   <= 1'b1;
                mosi <= 1'b0;
            end else if (w_fin) begin
                rx_data <= r_rx_sh;
                done    <= 1'b1;
                busy    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances cover N=1/D=2, N=2/D=2, N=1/D=1.
// Frames are measured edge by edge and compared with values from the frame rules.
module tb_spi_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] tx_data = '0;
    logic        loopback = 1'b0;
    logic        miso_drv = 1'b0;
    int          sel = 0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    logic [7:0]  a_rx, c_rx;
    logic [15:0] b_rx;
    logic a_busy, a_done, a_sclk, a_ss, a_mosi, a_miso;
    logic b_busy, b_done, b_sclk, b_ss, b_mosi, b_miso;
    logic c_busy, c_done, c_sclk, c_ss, c_mosi, c_miso;

    logic [15:0] m_rx;
    logic m_busy, m_done, m_sclk, m_ss, m_mosi;

    typedef struct {
        int          c0;
        int          cd;
        int          ss_rise;
        int          done_e;
        int          n_rise;
        int          min_hi;
        int          max_hi;
        logic [15:0] mosi_bits;
        logic [15:0] rx;
        logic        ss0;
        logic        busy0;
        logic        mosi0;
        bit          sclk_ss_bad;
        bit          mosi_hi_bad;
        bit          busy_drop;
    } res_t;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign a_miso = loopback ? a_mosi : miso_drv;
    assign b_miso = loopback ? b_mosi : miso_drv;
    assign c_miso = loopback ? c_mosi : miso_drv;

    spi_master #(.N_SLAVES(1), .CLK_DIV(2)) u_a (
        .clk(clk), .rst(rst), .start(start && sel == 0),
        .tx_data(tx_data[7:0]), .rx_data(a_rx), .busy(a_busy),
        .done(a_done), .sclk(a_sclk), .ss(a_ss), .mosi(a_mosi),
        .miso(a_miso)
    );

    spi_master #(.N_SLAVES(2), .CLK_DIV(2)) u_b (
        .clk(clk), .rst(rst), .start(start && sel == 1),
        .tx_data(tx_data), .rx_data(b_rx), .busy(b_busy),
        .done(b_done), .sclk(b_sclk), .ss(b_ss), .mosi(b_mosi),
        .miso(b_miso)
    );

    spi_master #(.N_SLAVES(1), .CLK_DIV(1)) u_c (
        .clk(clk), .rst(rst), .start(start && sel == 2),
        .tx_data(tx_data[7:0]), .rx_data(c_rx), .busy(c_busy),
        .done(c_done), .sclk(c_sclk), .ss(c_ss), .mosi(c_mosi),
        .miso(c_miso)
    );

    always_comb begin
        m_rx = {8'h00, a_rx};
        m_busy = a_busy; m_done = a_done; m_sclk = a_sclk;
        m_ss = a_ss; m_mosi = a_mosi;
        if (sel == 1) begin
            m_rx = b_rx;
            m_busy = b_busy; m_done = b_done; m_sclk = b_sclk;
            m_ss = b_ss; m_mosi = b_mosi;
        end else if (sel == 2) begin
            m_rx = {8'h00, c_rx};
            m_busy = c_busy; m_done = c_done; m_sclk = c_sclk;
            m_ss = c_ss; m_mosi = c_mosi;
        end
    end

    // Runs one frame on instance sel; caller sits #1 after a clk edge.
    task automatic run_frame(input logic [15:0] tx, input logic [15:0] mvec,
                             input int inject, output res_t r);
        int   t;
        int   n;
        int   hi_start;
        logic p_sclk, p_ss, p_mosi;
        t = (sel == 1) ? 16 : 8;
        r.ss_rise = -1; r.done_e = -1; r.n_rise = 0;
        r.min_hi = 1000; r.max_hi = 0; r.mosi_bits = '0; r.rx = '0;
        r.sclk_ss_bad = 0; r.mosi_hi_bad = 0; r.busy_drop = 0;
        r.cd = -1;
        hi_start = 0;
        miso_drv = mvec[t-1];
        tx_data = tx;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        r.c0 = cyc;
        r.ss0 = m_ss; r.busy0 = m_busy; r.mosi0 = m_mosi;
        p_sclk = m_sclk; p_ss = m_ss; p_mosi = m_mosi;
        n = 0;
        while (n < 400) begin
            @(posedge clk);
            n++;
            #1;
            if (n == inject - 1) begin
                start = 1'b1;
                tx_data = '0;
            end
            if (n == inject) start = 1'b0;
            if (m_done) begin
                r.done_e = n;
                r.cd = cyc;
                r.rx = m_rx;
                break;
            end
            if (!m_busy) r.busy_drop = 1;
            if (!p_sclk && m_sclk) begin
                r.mosi_bits = {r.mosi_bits[14:0], m_mosi};
                r.n_rise++;
                hi_start = n;
                if (r.n_rise < t) miso_drv = mvec[t-1-r.n_rise];
            end
            if (p_sclk && !m_sclk) begin
                if (n - hi_start < r.min_hi) r.min_hi = n - hi_start;
                if (n - hi_start > r.max_hi) r.max_hi = n - hi_start;
            end
            if (p_sclk && m_sclk && p_mosi != m_mosi) r.mosi_hi_bad = 1;
            if (!p_ss && m_ss) r.ss_rise = n;
            if (m_ss && m_sclk) r.sclk_ss_bad = 1;
            p_sclk = m_sclk; p_ss = m_ss; p_mosi = m_mosi;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int s = 0; s < 3; s++) begin
                sel = s;
                #1;
                n_cmp++;
                if ({m_ss, m_sclk, m_mosi, m_busy, m_done} !== 5'b10000) begin
                    n_bad++;
                    $display("FAIL reset_out[%0d,%0d]: got %b want 10000",
                             pass, s, {m_ss, m_sclk, m_mosi, m_busy, m_done});
                end
                n_cmp++;
                if (m_rx !== 16'h0000) begin
                    n_bad++;
                    $display("FAIL reset_rx[%0d,%0d]: got %h want 0000",
                             pass, s, m_rx);
                end
            end
            if (pass == 0) begin
                rst = 1'b1;
                repeat (5) @(posedge clk);
                #1;
            end
        end
        sel = 0;
    endtask

    task automatic test_loopback();
        res_t r;
        sel = 0; loopback = 1'b1;
        @(posedge clk); #1;
        run_frame(16'h00A5, 16'h0000, -10, r);
        n_cmp++;
        if ({r.ss0, r.busy0, r.mosi0} !== 3'b011) begin
            n_bad++;
            $display("FAIL lb_edge0: got %b want 011", {r.ss0, r.busy0, r.mosi0});
        end
        n_cmp++;
        if (r.n_rise != 8 || r.min_hi != 2 || r.max_hi != 2) begin
            n_bad++;
            $display("FAIL lb_sclk: got rises %0d hi %0d..%0d want 8 hi 2..2",
                     r.n_rise, r.min_hi, r.max_hi);
        end
        n_cmp++;
        if (r.ss_rise != 34) begin
            n_bad++;
            $display("FAIL lb_ss_rise: got %0d want 34", r.ss_rise);
        end
        n_cmp++;
        if (r.done_e != 36 || r.rx !== 16'h00A5) begin
            n_bad++;
            $display("FAIL lb_done: got edge %0d rx %h want 36 00a5",
                     r.done_e, r.rx);
        end
        n_cmp++;
        if (r.mosi_bits[7:0] !== 8'hA5 || r.sclk_ss_bad || r.mosi_hi_bad
            || r.busy_drop) begin
            n_bad++;
            $display("FAIL lb_wave: got mosi %h flags %b%b%b want a5 000",
                     r.mosi_bits[7:0], r.sclk_ss_bad, r.mosi_hi_bad, r.busy_drop);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (m_done !== 1'b0 || m_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL lb_done_pulse: got done %b busy %b want 0 0",
                     m_done, m_busy);
        end
    endtask

    task automatic test_two_slave();
        res_t r;
        sel = 1; loopback = 1'b0;
        @(posedge clk); #1;
        run_frame(16'h3CC3, 16'hFFFF, -10, r);
        n_cmp++;
        if (r.mosi_bits !== 16'b0011110011000011 || r.n_rise != 16) begin
            n_bad++;
            $display("FAIL two_mosi: got %b (%0d) want 0011110011000011 (16)",
                     r.mosi_bits, r.n_rise);
        end
        n_cmp++;
        if (r.done_e != 68 || r.rx !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL two_done: got edge %0d rx %h want 68 ffff",
                     r.done_e, r.rx);
        end
    endtask

    task automatic test_back_to_back();
        res_t r1, r2;
        logic [7:0] tx2;
        sel = 0; loopback = 1'b1;
        tx2 = 8'($urandom);
        @(posedge clk); #1;
        run_frame(16'h00A5, 16'h0000, 10, r1);
        run_frame({8'h00, tx2}, 16'h0000, -10, r2);
        n_cmp++;
        if (r1.rx !== 16'h00A5 || r1.mosi_bits[7:0] !== 8'hA5) begin
            n_bad++;
            $display("FAIL busy_ignore: got rx %h mosi %h want 00a5 a5",
                     r1.rx, r1.mosi_bits[7:0]);
        end
        n_cmp++;
        if (r2.c0 != r1.cd + 1) begin
            n_bad++;
            $display("FAIL b2b_accept: got start cycle %0d want %0d",
                     r2.c0, r1.cd + 1);
        end
        n_cmp++;
        if ((r2.c0 - (r1.c0 + r1.ss_rise)) < 3) begin
            n_bad++;
            $display("FAIL b2b_gap: got %0d want >= 3",
                     r2.c0 - (r1.c0 + r1.ss_rise));
        end
        n_cmp++;
        if (r2.done_e != 36 || r2.rx !== {8'h00, tx2}) begin
            n_bad++;
            $display("FAIL b2b_frame2: got edge %0d rx %h want 36 %h",
                     r2.done_e, r2.rx, {8'h00, tx2});
        end
    endtask

    task automatic test_reset_midframe();
        res_t r;
        bit   saw_done;
        logic [7:0] txr;
        sel = 0; loopback = 1'b1;
        @(posedge clk); #1;
        tx_data = 16'h00A5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({m_ss, m_sclk, m_busy, m_mosi} !== 4'b1000) begin
            n_bad++;
            $display("FAIL rst_mid: got ss,sclk,busy,mosi %b want 1000",
                     {m_ss, m_sclk, m_busy, m_mosi});
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        saw_done = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (m_done || m_busy || !m_ss) saw_done = 1;
        end
        n_cmp++;
        if (saw_done) begin
            n_bad++;
            $display("FAIL rst_no_done: got activity 1 want 0");
        end
        txr = 8'($urandom);
        run_frame({8'h00, txr}, 16'h0000, -10, r);
        n_cmp++;
        if (r.done_e != 36 || r.rx !== {8'h00, txr}) begin
            n_bad++;
            $display("FAIL rst_recover: got edge %0d rx %h want 36 %h",
                     r.done_e, r.rx, {8'h00, txr});
        end
    endtask

    task automatic test_clkdiv1();
        res_t r;
        sel = 2; loopback = 1'b1;
        @(posedge clk); #1;
        run_frame(16'h005A, 16'h0000, -10, r);
        n_cmp++;
        if (r.done_e != 18 || r.rx !== 16'h005A) begin
            n_bad++;
            $display("FAIL div1_done: got edge %0d rx %h want 18 005a",
                     r.done_e, r.rx);
        end
        n_cmp++;
        if (r.n_rise != 8 || r.min_hi != 1 || r.max_hi != 1 || r.ss_rise != 17) begin
            n_bad++;
            $display("FAIL div1_wave: got rises %0d hi %0d..%0d ss %0d want 8 1..1 17",
                     r.n_rise, r.min_hi, r.max_hi, r.ss_rise);
        end
    endtask

    task automatic test_random();
        res_t r;
        logic [15:0] tx, mv, msk;
        int t, d;
        loopback = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sel = (i % 2 == 0) ? 1 : 2;
            t = (sel == 1) ? 16 : 8;
            d = (sel == 2) ? 1 : 2;
            msk = (sel == 1) ? 16'hFFFF : 16'h00FF;
            tx = 16'($urandom) & msk;
            mv = 16'($urandom) & msk;
            @(posedge clk); #1;
            run_frame(tx, mv, -10, r);
            n_cmp++;
            if (r.rx !== mv || (r.mosi_bits & msk) !== tx) begin
                n_bad++;
                $display("FAIL rand[%0d]: got rx %h mosi %h want %h %h",
                         i, r.rx, r.mosi_bits & msk, mv, tx);
            end
            n_cmp++;
            if (r.done_e != (2 * t + 2) * d || r.ss_rise != (2 * t + 1) * d) begin
                n_bad++;
                $display("FAIL rand_time[%0d]: got done %0d ss %0d want %0d %0d",
                         i, r.done_e, r.ss_rise, (2 * t + 2) * d, (2 * t + 1) * d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_two_slave();
        test_back_to_back();
        test_reset_midframe();
        test_clkdiv1();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
